// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: a valid/ready command becomes one AXI read or write.
// Optional stall timeout is compiled in when AXIM_TIMEOUT_EN is defined.
module axi4lite_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [2:0]        AWPROT,
    output logic              WVALID,
    input  logic              WREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [3:0]        WSTRB,
    input  logic              BVALID,
    output logic              BREADY,
    input  logic [1:0]        BRESP,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [2:0]        ARPROT,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RSP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              write_q, write_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;

`ifdef AXIM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             expired;
    // The cycle with cnt_q == TIMEOUT_CYCLES-1 is the last one allowed to complete.
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifdef AXIM_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    awvalid_d = cmd_write;
                    wvalid_d  = cmd_write;
                    arvalid_d = !cmd_write;
                    rdata_d   = '0;
                    resp_d    = '0;
`ifdef AXIM_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                    state_d   = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (AWREADY) awvalid_d = 1'b0;
                if (WREADY)  wvalid_d  = 1'b0;
                if (BVALID) begin
                    resp_d    = BRESP;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    state_d   = RSP;
                end
`ifdef AXIM_TIMEOUT_EN
                else if (expired) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    resp_d    = 2'b10;
                    timeout_d = 1'b1;
                    state_d   = RSP;
                end
                cnt_d = cnt_q + 1'b1;
`endif
            end
            READ: begin
                if (ARREADY) arvalid_d = 1'b0;
                if (RVALID) begin
                    rdata_d   = RDATA;
                    resp_d    = RRESP;
                    arvalid_d = 1'b0;
                    state_d   = RSP;
                end
`ifdef AXIM_TIMEOUT_EN
                else if (expired) begin
                    arvalid_d = 1'b0;
                    rdata_d   = '0;
                    resp_d    = 2'b10;
                    timeout_d = 1'b1;
                    state_d   = RSP;
                end
                cnt_d = cnt_q + 1'b1;
`endif
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
`ifdef AXIM_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
`ifdef AXIM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign BREADY    = (state_q == WRITE);
    assign RREADY    = (state_q == READ);
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
`ifdef AXIM_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif
    assign AWVALID = awvalid_q;
    assign AWADDR  = addr_q;
    assign AWPROT  = 3'b000;
    assign WVALID  = wvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign ARVALID = arvalid_q;
    assign ARADDR  = addr_q;
    assign ARPROT  = 3'b000;

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: programmable-latency slave, vector table plus hand-written corner cases.
module tb_axi4lite_master;

`ifdef AXIM_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 256;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [2:0]  AWPROT, ARPROT;
    logic [1:0]  BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi4lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    // Slave: each READY/VALID fires at a programmed cycle index t (t=0 is the first VALID cycle).
    int unsigned aw_at = 0, w_at = 0, b_at = 0, ar_at = 0, r_at = 0;
    logic [1:0]  s_resp = '0;
    logic [31:0] s_rdata = '0;
    int unsigned t_q = 0;
    logic        aw_done_q = 1'b0, w_done_q = 1'b0, ar_done_q = 1'b0;

    always_comb begin
        AWREADY = AWVALID && (t_q >= aw_at);
        WREADY  = WVALID && (t_q >= w_at);
        BVALID  = BREADY && (aw_done_q || AWREADY) && (w_done_q || WREADY) && (t_q >= b_at);
        ARREADY = ARVALID && (t_q >= ar_at);
        RVALID  = RREADY && (ar_done_q || ARREADY) && (t_q >= r_at);
        BRESP   = s_resp;
        RRESP   = s_resp;
        RDATA   = s_rdata;
    end

    int unsigned aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, violations = 0;
    logic [31:0] aw_addr_seen = '0, w_data_seen = '0, ar_addr_seen = '0;
    logic [3:0]  w_strb_seen = '0;
    logic        aw_pend_q = 1'b0, w_pend_q = 1'b0, ar_pend_q = 1'b0, rst_q = 1'b0;
    logic [31:0] awaddr_p = '0, wdata_p = '0, araddr_p = '0;

    always @(posedge ACLK) begin
        t_q       <= (BREADY || RREADY) ? t_q + 1 : 0;
        aw_done_q <= BREADY && (aw_done_q || (AWVALID && AWREADY));
        w_done_q  <= BREADY && (w_done_q || (WVALID && WREADY));
        ar_done_q <= RREADY && (ar_done_q || (ARVALID && ARREADY));
        if (AWVALID && AWREADY) begin aw_cnt <= aw_cnt + 1; aw_addr_seen <= AWADDR; end
        if (WVALID && WREADY) begin w_cnt <= w_cnt + 1; w_data_seen <= WDATA; w_strb_seen <= WSTRB; end
        if (BVALID && BREADY) b_cnt <= b_cnt + 1;
        if (ARVALID && ARREADY) begin ar_cnt <= ar_cnt + 1; ar_addr_seen <= ARADDR; end
        if (RVALID && RREADY) r_cnt <= r_cnt + 1;
        // A pending VALID may only vanish after reset or a timeout abort; payload must hold.
        if (!rst_q && !rsp_timeout) begin
            if (aw_pend_q && (!AWVALID || AWADDR != awaddr_p)) violations <= violations + 1;
            if (w_pend_q && (!WVALID || WDATA != wdata_p)) violations <= violations + 1;
            if (ar_pend_q && (!ARVALID || ARADDR != araddr_p)) violations <= violations + 1;
        end
        aw_pend_q <= AWVALID && !AWREADY;
        w_pend_q  <= WVALID && !WREADY;
        ar_pend_q <= ARVALID && !ARREADY;
        awaddr_p  <= AWADDR;
        wdata_p   <= WDATA;
        araddr_p  <= ARADDR;
        rst_q     <= ARESET;
    end

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_slave(input int unsigned aw, w, b, ar, r, input logic [1:0] resp,
                             input logic [31:0] rd);
        aw_at = aw; w_at = w; b_at = b; ar_at = ar; r_at = r; s_resp = resp; s_rdata = rd;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, wdata, input logic [3:0] strb);
        @(negedge ACLK);
        check("cmd_ready before issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    // Returns number of negedges after the accept edge until rsp_valid is seen (first = 1).
    task automatic wait_rsp(output int unsigned lat);
        lat = 0;
        do begin
            @(negedge ACLK);
            lat++;
        end while (!rsp_valid && lat < 60);
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_valid timeout: got 0 after %0d cycles, expected 1", lat);
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge ACLK);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata;
        logic [3:0]  strb;
        int unsigned aw, w, b, ar, r;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int unsigned exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int unsigned lat;
        int unsigned aw0, w0, b0, ar0, r0;
        logic [31:0] hold;
        logic [4:0]  aw_exp;
        logic        rsp_seen;

        vecs[0] = '{1'b1, 32'h4,  32'h0000_00A5, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         2'b00, 32'h0,         2};
        vecs[1] = '{1'b0, 32'h8,  32'h0,         4'h0, 0, 0, 0, 0, 3, 2'b00, 32'h1234_5678, 2'b00, 32'h1234_5678, 5};
        vecs[2] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'h3, 1, 4, 0, 0, 0, 2'b10, 32'h0,         2'b10, 32'h0,         6};
        vecs[3] = '{1'b0, 32'hC,  32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 2};
        vecs[4] = '{1'b1, 32'h20, 32'h1122_3344, 4'h8, 2, 0, 3, 0, 0, 2'b11, 32'h0,         2'b11, 32'h0,         5};
        vecs[5] = '{1'b0, 32'h24, 32'h0,         4'h0, 0, 0, 0, 2, 1, 2'b11, 32'h0BAD_F00D, 2'b11, 32'h0BAD_F00D, 4};

        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset valids", {28'd0, AWVALID, WVALID, ARVALID, rsp_valid}, 32'd0);
        check("reset readys", {30'd0, BREADY, RREADY}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_resp/timeout", {29'd0, rsp_resp, rsp_timeout}, 32'd0);
        check("reset AWADDR", AWADDR, 32'd0);
        check("reset WDATA", WDATA, 32'd0);

        for (int i = 0; i < 6; i++) begin
            set_slave(vecs[i].aw, vecs[i].w, vecs[i].b, vecs[i].ar, vecs[i].r,
                      vecs[i].sresp, vecs[i].srdata);
            aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            wait_rsp(lat);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d rsp_resp", i), {30'd0, rsp_resp}, {30'd0, vecs[i].exp_resp});
            check($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d rsp_write", i), {31'd0, rsp_write}, {31'd0, vecs[i].wr});
            check($sformatf("v%0d rsp_timeout", i), {31'd0, rsp_timeout}, 32'd0);
            check($sformatf("v%0d valids idle", i), {29'd0, AWVALID, WVALID, ARVALID}, 32'd0);
            if (vecs[i].wr) begin
                check($sformatf("v%0d aw/w/b count", i),
                      {aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0} == {32'd1, 32'd1, 32'd1, 32'd0}, 32'd1);
                check($sformatf("v%0d AWADDR", i), aw_addr_seen, vecs[i].addr);
                check($sformatf("v%0d WDATA", i), w_data_seen, vecs[i].wdata);
                check($sformatf("v%0d WSTRB", i), {28'd0, w_strb_seen}, {28'd0, vecs[i].strb});
            end else begin
                check($sformatf("v%0d ar/r count", i),
                      {ar_cnt - ar0, r_cnt - r0, aw_cnt - aw0} == {32'd1, 32'd1, 32'd0}, 32'd1);
                check($sformatf("v%0d ARADDR", i), ar_addr_seen, vecs[i].addr);
            end
            release_rsp();
        end

        // AWREADY at t=1, WREADY at t=4: AWVALID falls alone, WVALID held until its handshake.
        set_slave(1, 4, 0, 0, 0, 2'b10, 32'h0);
        aw_exp = 5'b00011;
        issue(1'b1, 32'h14, 32'h0F0F_0F0F, 4'hF);
        for (int t = 0; t < 5; t++) begin
            @(negedge ACLK);
            check($sformatf("split t%0d AWVALID", t), {31'd0, AWVALID}, {31'd0, aw_exp[t]});
            check($sformatf("split t%0d WVALID/BREADY", t), {30'd0, WVALID, BREADY}, 32'd3);
        end
        @(negedge ACLK);
        check("split rsp_valid/resp", {29'd0, rsp_valid, rsp_resp}, 32'b110);
        check("split valids cleared", {30'd0, AWVALID, WVALID}, 32'd0);
        release_rsp();

        // Response back-pressure: fields hold and a waiting command is not taken.
        set_slave(0, 0, 0, 0, 0, 2'b01, 32'h55AA_55AA);
        issue(1'b0, 32'h18, 32'h0, 4'h0);
        wait_rsp(lat);
        hold = rsp_rdata;
        check("hold initial rdata", hold, 32'h55AA_55AA);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h7; cmd_wstrb = 4'h1;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check($sformatf("hold c%0d rsp_valid/cmd_ready", k), {30'd0, rsp_valid, cmd_ready}, 32'b10);
            check($sformatf("hold c%0d rdata", k), rsp_rdata, hold);
            check($sformatf("hold c%0d resp/AWVALID", k), {29'd0, rsp_resp, AWVALID}, 32'b010);
        end
        release_rsp();
        @(negedge ACLK);
        check("hold release idle", {29'd0, cmd_ready, rsp_valid, AWVALID}, 32'b100);
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        @(negedge ACLK);
        check("hold next cmd AWVALID", {31'd0, AWVALID}, 32'd1);
        check("hold next cmd AWADDR", AWADDR, 32'h30);
        wait_rsp(lat);
        check("hold next cmd rsp_rdata", rsp_rdata, 32'd0);
        release_rsp();

        // Reset while AW/W are stalled: everything returns to reset values, no response.
        set_slave(1000, 1000, 1000, 0, 0, 2'b00, 32'h0);
        issue(1'b1, 32'h40, 32'hAAAA_0001, 4'hF);
        @(negedge ACLK);
        check("pre-reset AWVALID", {31'd0, AWVALID}, 32'd1);
        @(negedge ACLK);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("mid-reset valids", {28'd0, AWVALID, WVALID, ARVALID, rsp_valid}, 32'd0);
        check("mid-reset cmd_ready/BREADY", {30'd0, cmd_ready, BREADY}, 32'b10);
        check("mid-reset AWADDR", AWADDR, 32'd0);
        rsp_seen = 1'b0;
        repeat (4) begin
            @(negedge ACLK);
            if (rsp_valid) rsp_seen = 1'b1;
        end
        check("mid-reset no response", {31'd0, rsp_seen}, 32'd0);

`ifdef AXIM_TIMEOUT_EN
        // Slave never answers the read: abort after TO cycles in READ.
        set_slave(0, 0, 0, 1000, 1000, 2'b00, 32'hFFFF_FFFF);
        issue(1'b0, 32'h50, 32'h0, 4'h0);
        wait_rsp(lat);
        check("timeout latency", lat, TO + 1);
        check("timeout resp/flag", {29'd0, rsp_resp, rsp_timeout}, 32'b101);
        check("timeout rdata", rsp_rdata, 32'd0);
        check("timeout ARVALID/RREADY", {30'd0, ARVALID, RREADY}, 32'd0);
        release_rsp();
`endif

        check("protocol violations", violations, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
